// File: rtl/tic_tac_toe_pkg.sv
// Shared definitions for the tic-tac-toe game: cell encoding, game status
// codes, player identities and the table of the eight winning lines.
package tic_tac_toe_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_A     = 2'b01,
    CELL_B     = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    DRAW        = 2'b00,
    A_WINS      = 2'b01,
    B_WINS      = 2'b10,
    IN_PROGRESS = 2'b11
  } status_e;

  localparam logic PLAYER_A = 1'b1;
  localparam logic PLAYER_B = 1'b0;

  localparam int NUM_CELLS    = 9;
  localparam int NUM_LINES    = 8;
  localparam int MAX_POSITION = 8;
  localparam int BOARD_W      = 2 * NUM_CELLS;

  // Rows, then columns, then the two diagonals, as row-major cell indices.
  localparam int WIN_LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Extracts the 2-bit mark of one cell from the packed board.
  function automatic logic [1:0] cellAt(input logic [BOARD_W-1:0] board, input int idx);
    return board[2*idx +: 2];
  endfunction

endpackage

// File: rtl/tic_tac_toe_win_check.sv
// Pure combinational evaluation of a board: reports whether player A or
// player B owns a complete line and whether every cell is occupied.
module tic_tac_toe_win_check
  import tic_tac_toe_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  output logic               aWin_o,
  output logic               bWin_o,
  output logic               full_o
);

  // Scan all eight lines for three matching marks, and all cells for a gap.
  always_comb begin
    aWin_o = 1'b0;
    bWin_o = 1'b0;
    full_o = 1'b1;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (cellAt(board_i, WIN_LINES[l][0]) == CELL_A &&
          cellAt(board_i, WIN_LINES[l][1]) == CELL_A &&
          cellAt(board_i, WIN_LINES[l][2]) == CELL_A) begin
        aWin_o = 1'b1;
      end
      if (cellAt(board_i, WIN_LINES[l][0]) == CELL_B &&
          cellAt(board_i, WIN_LINES[l][1]) == CELL_B &&
          cellAt(board_i, WIN_LINES[l][2]) == CELL_B) begin
        bWin_o = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (cellAt(board_i, i) == CELL_EMPTY) begin
        full_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tic_tac_toe.sv
// Tic-tac-toe referee. Every non-reset clock edge is a move attempt; legal
// moves are written to the board and the resulting status is registered on
// the same edge. A move that ends the game leaves current_turn on the mover,
// and from then on the whole game state is frozen until reset.
module tic_tac_toe (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] position,
  input  logic       player_select,
  output logic       current_turn,
  output logic [1:0] game_status
);

  import tic_tac_toe_pkg::*;

  logic [BOARD_W-1:0] board_q;
  logic [BOARD_W-1:0] board_d;
  logic               turn_q;
  logic               turn_d;
  status_e            status_q;
  status_e            status_d;

  logic               cellFree;
  logic               moveOk;
  cell_e              moverMark;
  logic               aWin;
  logic               bWin;
  logic               boardFull;

  // Decide whether the attempted move is legal and build the resulting board.
  always_comb begin
    cellFree = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (position == 4'(i)) begin
        cellFree = (cellAt(board_q, i) == CELL_EMPTY);
      end
    end
    moveOk = (status_q == IN_PROGRESS) &&
             (position <= 4'(MAX_POSITION)) &&
             cellFree &&
             (player_select == turn_q);
    moverMark = (player_select == PLAYER_A) ? CELL_A : CELL_B;
    board_d = board_q;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (moveOk && position == 4'(i)) begin
        board_d[2*i +: 2] = moverMark;
      end
    end
  end

  tic_tac_toe_win_check winCheck (
    .board_i (board_d),
    .aWin_o  (aWin),
    .bWin_o  (bWin),
    .full_o  (boardFull)
  );

  // Status follows the board including this edge's move; a win beats a full board.
  always_comb begin
    status_d = status_q;
    turn_d   = turn_q;
    if (moveOk) begin
      if (aWin) begin
        status_d = A_WINS;
      end else if (bWin) begin
        status_d = B_WINS;
      end else if (boardFull) begin
        status_d = DRAW;
      end else begin
        turn_d = ~turn_q;
      end
    end
  end

  // Game state registers; reset wins over any move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      board_q  <= '0;
      turn_q   <= PLAYER_A;
      status_q <= IN_PROGRESS;
    end else begin
      board_q  <= board_d;
      turn_q   <= turn_d;
      status_q <= status_d;
    end
  end

  assign current_turn = turn_q;
  assign game_status  = status_q;

endmodule

// File: tb/tb_tic_tac_toe.sv
// Self-checking bench for tic_tac_toe: directed game scenarios followed by
// randomized play, all compared against a cell-array reference model.
module tb_tic_tac_toe;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] position;
  logic       player_select;
  logic       current_turn;
  logic [1:0] game_status;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: cells hold 0 empty, 1 A, 2 B.
  int         mBoard [9];
  logic       mTurn;
  logic [1:0] mStatus;
  int         lines [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  tic_tac_toe dut (
    .clk           (clk),
    .reset         (reset),
    .position      (position),
    .player_select (player_select),
    .current_turn  (current_turn),
    .game_status   (game_status)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int modelWinner();
    for (int l = 0; l < 8; l++) begin
      if (mBoard[lines[l][0]] != 0 &&
          mBoard[lines[l][0]] == mBoard[lines[l][1]] &&
          mBoard[lines[l][1]] == mBoard[lines[l][2]])
        return mBoard[lines[l][0]];
    end
    return 0;
  endfunction

  function automatic logic [17:0] modelBoardBits();
    logic [17:0] bits;
    bits = '0;
    for (int i = 0; i < 9; i++) bits[2*i +: 2] = 2'(mBoard[i]);
    return bits;
  endfunction

  task automatic modelStep(input logic rst, input logic [3:0] pos, input logic ply);
    int empties;
    int w;
    if (rst) begin
      for (int i = 0; i < 9; i++) mBoard[i] = 0;
      mTurn   = 1'b1;
      mStatus = 2'b11;
      return;
    end
    if (mStatus == 2'b11 && pos < 9 && ply == mTurn) begin
      if (mBoard[pos] == 0) begin
        mBoard[pos] = ply ? 1 : 2;
        w = modelWinner();
        empties = 0;
        for (int i = 0; i < 9; i++) if (mBoard[i] == 0) empties++;
        if (w == 1)            mStatus = 2'b01;
        else if (w == 2)       mStatus = 2'b10;
        else if (empties == 0) mStatus = 2'b00;
        else                   mTurn   = ~mTurn;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] pos, input logic ply);
    @(negedge clk);
    reset         = rst;
    position      = pos;
    player_select = ply;
    @(posedge clk);
    modelStep(rst, pos, ply);
    #1;
    checkOutput("turn",   32'(current_turn), 32'(mTurn));
    checkOutput("status", 32'(game_status),  32'(mStatus));
    checkOutput("board",  32'(dut.board_q),  32'(modelBoardBits()));
  endtask

  // Moves are encoded as player*16 + position (player 1 = A).
  task automatic playMoves(input int moves[$]);
    foreach (moves[k]) applyStimulus(1'b0, 4'(moves[k] % 16), moves[k] >= 16);
  endtask

  initial begin
    int         seq[$];
    logic [3:0] pos;
    logic       ply;
    logic       rst;

    reset = 1'b1; position = '0; player_select = 1'b0;
    $display("[TB] starting tic_tac_toe bench");

    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("reset_status", 32'(game_status), 32'h3);
    checkOutput("reset_turn",   32'(current_turn), 32'h1);

    // Column 0 win for A; turn stays with A after the win.
    seq = '{16, 1, 19, 4, 22};
    playMoves(seq);
    checkOutput("colwin_status", 32'(game_status), 32'h1);
    checkOutput("colwin_turn",   32'(current_turn), 32'h1);

    // Anti-diagonal win, then two moves that must be ignored.
    applyStimulus(1'b1, 4'd0, 1'b0);
    seq = '{16, 1, 18, 3, 20, 5, 22, 7, 24};
    playMoves(seq);
    checkOutput("diagwin_status", 32'(game_status), 32'h1);
    checkOutput("diagwin_board",  32'(dut.board_q), 32'h01999);

    // Full board, no line: draw on the ninth move.
    applyStimulus(1'b1, 4'd0, 1'b0);
    seq = '{16, 1, 18, 4, 19, 5, 23, 6, 24};
    playMoves(seq);
    checkOutput("draw_status", 32'(game_status), 32'h0);

    // Wrong turn, invalid index, legal move, occupied cell.
    applyStimulus(1'b1, 4'd0, 1'b0);
    seq = '{4, 25, 16, 0};
    playMoves(seq);
    checkOutput("illegal_turn",   32'(current_turn), 32'h0);
    checkOutput("illegal_status", 32'(game_status),  32'h3);

    // B wins on the middle row.
    applyStimulus(1'b1, 4'd0, 1'b0);
    seq = '{16, 3, 17, 4, 24, 5};
    playMoves(seq);
    checkOutput("bwin_status", 32'(game_status), 32'h2);

    // Mid-game reset with a move presented on the same edge.
    applyStimulus(1'b1, 4'd0, 1'b0);
    seq = '{16, 1};
    playMoves(seq);
    applyStimulus(1'b1, 4'd2, 1'b1);
    checkOutput("midreset_board", 32'(dut.board_q), 32'h0);
    seq = '{17};
    playMoves(seq);
    checkOutput("midreset_turn", 32'(current_turn), 32'h0);

    // Randomized play, with held inputs and resets mostly after game over.
    pos = 4'd0;
    ply = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) < 2) ||
            (mStatus != 2'b11 && $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) != 0) begin
        pos = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(0, 8));
        ply = ($urandom_range(0, 99) < 85) ? mTurn : 1'($urandom_range(0, 1));
      end
      applyStimulus(rst, pos, ply);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
